sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//  Parametrised single-clock FIFO; successor to the 8x32 sync FIFO. Adds selectable
//  read mode (registered / first-word-fall-through), occupancy count, programmable
//  almost-full/almost-empty, synchronous flush and sticky overflow/underflow error
//  flags. Used as the general buffering element between producer/consumer stages.
// PARAMETERS
//  WIDTH     32  data word width in bits (>=1)
//  DEPTH     8   number of entries; power of two, >=2; ADDR = $clog2(DEPTH)
//  FWFT      0   0 = registered read (d_out valid 1 cycle after pop); 1 = fall-through
//  AF_LEVEL  6   almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  1   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
//  clk          in   1        clock, all state on rising edge
//  reset        in   1        asynchronous, active-high reset
//  cs           in   1        chip select; wr_en/rd_en/flush/clr_err ignored when 0
//  wr_en        in   1        write request
//  rd_en        in   1        read (pop) request
//  flush        in   1        synchronous empty-the-FIFO request
//  clr_err      in   1        clears sticky overflow/underflow
//  d_in         in   WIDTH    write data
//  d_out        out  WIDTH    read data
//  empty        out  1        count == 0
//  full         out  1        count == DEPTH
//  almost_empty out  1        count <= AE_LEVEL
//  almost_full  out  1        count >= AF_LEVEL
//  count        out  ADDR+1   current occupancy, 0..DEPTH
//  overflow     out  1        sticky: write attempted while full
//  underflow    out  1        sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (async, high): wr_ptr=rd_ptr=0, d_out=0, overflow=underflow=0 -> empty=1,
//    full=0, count=0, almost_empty=1, almost_full=0. Memory array not reset.
//  - Pointers ADDR+1 bits; wrap naturally mod 2*DEPTH. empty: ptrs equal; full: MSBs
//    differ, low ADDR bits equal. count = wr_ptr - rd_ptr (ADDR+1 bits, no overflow).
//  - wr_acc = cs & wr_en & !full & !flush; rd_acc = cs & rd_en & !empty & !flush.
//    Acceptance judged on pre-edge flags; writes to mem[wr_ptr[ADDR-1:0]].
//  - Simultaneous wr+rd, neither boundary: both accepted, count unchanged.
//    When full: only read accepted, overflow set. When empty: only write accepted,
//    underflow set; written word is NOT bypassed to d_out that cycle.
//  - FWFT=0: on rd_acc, d_out <= head word at next edge; otherwise d_out holds.
//  - FWFT=1: d_out = mem[rd_ptr] combinationally while !empty; 0 while empty.
//    Word written into empty FIFO visible on d_out 1 cycle after the write edge.
//  - flush (cs=1): next edge rd_ptr <= wr_ptr (FIFO empty); overrides wr/rd that
//    cycle; d_out holds in FWFT=0; error flags unaffected.
//  - overflow <= 1 on cs&wr_en&full; underflow <= 1 on cs&rd_en&empty (not during
//    flush). Cleared only by reset or cs&clr_err; set has priority over clear.
//  - cs=0: no state change at all; flags/count/d_out hold.
//  - Reset mid-burst: immediate return to reset values; in-flight data discarded.
//  - Status outputs (empty/full/almost_*/count) are combinational from pointers.
// TESTING (WIDTH=32, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1; run FWFT=0 and FWFT=1)
//  1 Write 1,10,100 then 4 reads -> d_out 1,10,100 in order; 4th read sets
//    underflow, empty=1, d_out holds 100 (FWFT=0).
//  2 Write 2**0..2**8 (9 writes) -> full=1 after 8th, count=8, overflow=1 on 9th;
//    8 reads return 1..128, 256 never stored; almost_full toggles at count 6->5.
//  3 Fill to 4, then 20 cycles of simultaneous wr+rd -> count stays 4, data in
//    order across pointer wrap (pointers pass 2*DEPTH), no flags set.
//  4 Full FIFO, simultaneous wr+rd -> read accepted, write dropped, count=7,
//    overflow=1; clr_err with cs=1 -> overflow=0.
//  5 Count=5, assert flush -> next edge count=0, empty=1, almost_empty=1; next
//    write 0xA5 then read -> 0xA5.
//  6 Reset pulse mid-burst (count=3) -> all outputs at reset values same cycle;
//    cs=0 with wr_en/rd_en high -> no change in count or flags.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty,
// synchronous flush, sticky error flags and selectable registered or fall-through read.
module sync_fifo_flags #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 8,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cs,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic                     flush,
    input  logic                     clr_err,
    input  logic [WIDTH-1:0]         d_in,
    output logic [WIDTH-1:0]         d_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR = $clog2(DEPTH);
    localparam logic [ADDR:0] PTR_ONE = (ADDR+1)'(1);
    localparam logic [ADDR:0] AF_CNT  = (ADDR+1)'(AF_LEVEL);
    localparam logic [ADDR:0] AE_CNT  = (ADDR+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          flush_req;
    logic          wr_acc;
    logic          rd_acc;
    logic          ovf_set;
    logic          unf_set;
    logic          err_clr;
    logic [WIDTH-1:0] head;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[ADDR] != rd_ptr_q[ADDR]) &&
                          (wr_ptr_q[ADDR-1:0] == rd_ptr_q[ADDR-1:0]);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_empty = (count <= AE_CNT);
    assign almost_full  = (count >= AF_CNT);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign flush_req = cs & flush;
    assign wr_acc    = cs & wr_en & ~full  & ~flush;
    assign rd_acc    = cs & rd_en & ~empty & ~flush;
    assign ovf_set   = cs & wr_en & full  & ~flush;
    assign unf_set   = cs & rd_en & empty & ~flush;
    assign err_clr   = cs & clr_err;

    assign head = mem_q[rd_ptr_q[ADDR-1:0]];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        // Flush blocks the write in the same cycle, so wr_ptr_q is the final write position.
        if (flush_req) begin
            rd_ptr_d = wr_ptr_q;
        end else if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end

        if (unf_set) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset; empty/full gate every visible read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[ADDR-1:0]] <= d_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign d_out = empty ? '0 : head;
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= head;
                end
            end

            assign d_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Drives a registered-read and a fall-through instance with identical stimulus and
// checks both against a queue-based model of the stored words and flags.
module tb_sync_fifo_flags;

    localparam int W = 32;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         cs = 1'b0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic         flush = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] d_in = '0;

    logic [W-1:0] d_out_r, d_out_f;
    logic         empty_r, full_r, ae_r, af_r, ovf_r, unf_r;
    logic         empty_f, full_f, ae_f, af_f, ovf_f, unf_f;
    logic [3:0]   count_r, count_f;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] sb[$];
    logic [W-1:0] m_dout_r = '0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1)) u_reg (
        .clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .clr_err(clr_err), .d_in(d_in), .d_out(d_out_r),
        .empty(empty_r), .full(full_r), .almost_empty(ae_r), .almost_full(af_r),
        .count(count_r), .overflow(ovf_r), .underflow(unf_r)
    );

    sync_fifo_flags #(.WIDTH(W), .DEPTH(D), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1)) u_fwft (
        .clk(clk), .reset(reset), .cs(cs), .wr_en(wr_en), .rd_en(rd_en),
        .flush(flush), .clr_err(clr_err), .d_in(d_in), .d_out(d_out_f),
        .empty(empty_f), .full(full_f), .almost_empty(ae_f), .almost_full(af_f),
        .count(count_f), .overflow(ovf_f), .underflow(unf_f)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag);
        int n;
        logic [W-1:0] head;
        n = sb.size();
        head = (n == 0) ? '0 : sb[0];
        chk({tag, ":cnt_r"},   64'(count_r), 64'(n));
        chk({tag, ":cnt_f"},   64'(count_f), 64'(n));
        chk({tag, ":empty_r"}, 64'(empty_r), 64'(n == 0));
        chk({tag, ":empty_f"}, 64'(empty_f), 64'(n == 0));
        chk({tag, ":full_r"},  64'(full_r),  64'(n == D));
        chk({tag, ":full_f"},  64'(full_f),  64'(n == D));
        chk({tag, ":ae_r"},    64'(ae_r),    64'(n <= 1));
        chk({tag, ":ae_f"},    64'(ae_f),    64'(n <= 1));
        chk({tag, ":af_r"},    64'(af_r),    64'(n >= 6));
        chk({tag, ":af_f"},    64'(af_f),    64'(n >= 6));
        chk({tag, ":ovf_r"},   64'(ovf_r),   64'(m_ovf));
        chk({tag, ":ovf_f"},   64'(ovf_f),   64'(m_ovf));
        chk({tag, ":unf_r"},   64'(unf_r),   64'(m_unf));
        chk({tag, ":unf_f"},   64'(unf_f),   64'(m_unf));
        chk({tag, ":dout_r"},  64'(d_out_r), 64'(m_dout_r));
        chk({tag, ":dout_f"},  64'(d_out_f), 64'(head));
    endtask

    // One clock: drive after the falling edge, check fall-through head before the
    // rising edge, check everything 1 time unit after it, return on the falling edge.
    task automatic cyc(input logic c, input logic w, input logic r, input logic f,
                       input logic cl, input logic [W-1:0] din, input string tag);
        logic mfull, mempty, wacc, racc;
        logic [W-1:0] exp;
        exp = '0;
        cs = c; wr_en = w; rd_en = r; flush = f; clr_err = cl; d_in = din;
        mfull  = (sb.size() == D);
        mempty = (sb.size() == 0);
        wacc = c && w && !mfull  && !f;
        racc = c && r && !mempty && !f;
        if (c && w && mfull && !f)       m_ovf = 1'b1;
        else if (c && cl)                m_ovf = 1'b0;
        if (c && r && mempty && !f)      m_unf = 1'b1;
        else if (c && cl)                m_unf = 1'b0;
        #1;
        if (racc) begin
            exp = sb.pop_front();
            chk({tag, ":fwft_head"}, 64'(d_out_f), 64'(exp));
            m_dout_r = exp;
        end
        if (wacc) sb.push_back(din);
        if (c && f) sb.delete();
        @(posedge clk);
        #1;
        if (racc) chk({tag, ":rd_data"}, 64'(d_out_r), 64'(exp));
        check_status(tag);
        @(negedge clk);
    endtask

    initial begin
        #2;
        check_status("reset");
        #10;
        reset = 1'b0;
        @(negedge clk);

        // 1: three writes, four reads; last read underflows and d_out holds
        cyc(1, 1, 0, 0, 0, 32'd1,   "t1_wr");
        cyc(1, 1, 0, 0, 0, 32'd10,  "t1_wr");
        cyc(1, 1, 0, 0, 0, 32'd100, "t1_wr");
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, '0, "t1_rd");
        chk("t1_unf", 64'(unf_r), 64'd1);
        chk("t1_hold", 64'(d_out_r), 64'd100);
        cyc(1, 0, 0, 0, 1, '0, "t1_clr");
        chk("t1_unf_clr", 64'(unf_r), 64'd0);

        // 2: nine writes of powers of two; ninth overflows
        for (int i = 0; i < 9; i++) begin
            cyc(1, 1, 0, 0, 0, 32'(1 << i), "t2_wr");
            if (i == 7) chk("t2_full", 64'(full_r), 64'd1);
        end
        chk("t2_ovf", 64'(ovf_f), 64'd1);
        for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, 0, '0, "t2_rd");
        chk("t2_last", 64'(d_out_r), 64'd128);
        cyc(1, 0, 0, 0, 1, '0, "t2_clr");

        // 3: fill to four then long simultaneous traffic across pointer wrap
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 32'h300 + 32'(i), "t3_fill");
        for (int i = 0; i < 20; i++) cyc(1, 1, 1, 0, 0, 32'h400 + 32'(i), "t3_rw");
        chk("t3_cnt", 64'(count_r), 64'd4);
        chk("t3_ovf", 64'(ovf_r), 64'd0);
        chk("t3_unf", 64'(unf_r), 64'd0);

        // 4: full FIFO, simultaneous wr+rd drops the write and flags overflow
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 32'h500 + 32'(i), "t4_fill");
        cyc(1, 1, 1, 0, 0, 32'hDEAD, "t4_rw");
        chk("t4_cnt", 64'(count_r), 64'd7);
        chk("t4_ovf", 64'(ovf_r), 64'd1);
        cyc(1, 0, 0, 0, 1, '0, "t4_clr");
        chk("t4_ovf_clr", 64'(ovf_r), 64'd0);

        // 5: count 5, flush, then a fresh write/read
        cyc(1, 0, 1, 0, 0, '0, "t5_drain");
        cyc(1, 0, 1, 0, 0, '0, "t5_drain");
        chk("t5_cnt5", 64'(count_r), 64'd5);
        cyc(1, 0, 0, 1, 0, '0, "t5_flush");
        chk("t5_empty", 64'(empty_r), 64'd1);
        cyc(1, 1, 0, 0, 0, 32'hA5, "t5_wr");
        cyc(1, 0, 1, 0, 0, '0, "t5_rd");
        chk("t5_a5", 64'(d_out_r), 64'hA5);

        // 6: asynchronous reset mid-burst, then deselected traffic
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0, 32'h600 + 32'(i), "t6_fill");
        cs = 1'b1; wr_en = 1'b1; d_in = 32'h777;
        #2;
        reset = 1'b1;
        #1;
        sb.delete();
        m_dout_r = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_status("t6_rst");
        cs = 1'b0; wr_en = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        cyc(1, 1, 0, 0, 0, 32'h11, "t6_wr");
        cyc(1, 1, 0, 0, 0, 32'h22, "t6_wr");
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 1, 1, 32'h99, "t6_nocs");
        chk("t6_cnt", 64'(count_f), 64'd2);
        cyc(1, 0, 1, 0, 0, '0, "t6_rd");
        chk("t6_data", 64'(d_out_r), 64'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
